// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: FSM states, the stored entry layout
// and the post-trigger depth clamp.
package commit_trace_pkg;

   localparam int XLEN_D = 32;
   localparam int TSW_D  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } trace_state_t;

   typedef struct packed {
      logic [XLEN_D-1:0] pc;
      logic [4:0]        rd;
      logic [XLEN_D-1:0] data;
      logic [TSW_D-1:0]  ts;
      logic              trig;
   } trace_entry_t;

   // Capping at depth-1 keeps the trigger entry inside the ring.
   function automatic int unsigned clamp_post(input int unsigned requested,
                                              input int unsigned depth);
      return (requested > depth - 1) ? depth - 1 : requested;
   endfunction

endpackage

// File: rtl/commit_trace_buf_trace_ring.sv
// Circular store of trace entries with oldest/write pointers, fill level and
// sticky overflow. A write into a full ring evicts the oldest entry.
module trace_ring
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       flush,
   input  logic                       wr_en,
   input  trace_entry_t               wr_entry,
   input  logic                       rd_adv,
   output trace_entry_t               rd_entry,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   trace_entry_t    mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   // NOTE: state registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
      end else if (wr_en) begin
         wr_ptr <= wr_ptr + 1'b1;
         if (level == FULL) begin
            rd_ptr   <= rd_ptr + 1'b1;
            overflow <= 1'b1;
         end else begin
            level <= level + 1'b1;
         end
      end else if (rd_adv && level != '0) begin
         rd_ptr <= rd_ptr + 1'b1;
         level  <= level - 1'b1;
      end
   end

   // NOTE: the storage array has no reset; an entry is only observable once written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_entry;
   end

   assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/commit_trace_buf.sv
// Commit trace capture: watches the writeback stream, freezes a ring of recent
// commits around a trigger, then drains it oldest-first over valid/ready.
module commit_trace_buf
   import commit_trace_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 16,
   parameter int TSW       = 16,
   parameter bit FILTER_X0 = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    commit_valid,
   input  logic [XLEN-1:0]         commit_pc,
   input  logic [4:0]              commit_rd,
   input  logic [XLEN-1:0]         commit_data,
   input  logic                    arm,
   input  logic                    abort,
   input  logic                    trig_rd_en,
   input  logic [4:0]              trig_rd,
   input  logic                    trig_pc_en,
   input  logic [XLEN-1:0]         trig_pc,
   input  logic [$clog2(DEPTH):0]  post_count,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [XLEN-1:0]         rd_pc,
   output logic [4:0]              rd_rd,
   output logic [XLEN-1:0]         rd_data,
   output logic [TSW-1:0]          rd_ts,
   output logic                    rd_trig,
   output logic [1:0]              state_o,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    overflow
);

   localparam int CW = $clog2(DEPTH) + 1;

   trace_state_t   state_q, state_d;
   logic [CW-1:0]  rem_q, rem_d;
   logic [TSW-1:0] ts_q;
   logic           loggable, hit;
   logic           wr_en, wr_trig, clear, flush, rd_adv;
   logic [CW-1:0]  post_eff;
   trace_entry_t   wr_entry, head;

   assign loggable = commit_valid && !(FILTER_X0 && commit_rd == 5'd0);
   assign hit      = loggable && ((trig_rd_en && commit_rd == trig_rd) ||
                                  (trig_pc_en && commit_pc == trig_pc));
   assign post_eff = CW'(clamp_post(32'(post_count), DEPTH));
   assign rd_valid = (state_q == DONE) && (level != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         ts_q    <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         ts_q    <= ts_q + 1'b1;
      end
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      wr_en   = 1'b0;
      wr_trig = 1'b0;
      clear   = 1'b0;
      flush   = 1'b0;
      rd_adv  = 1'b0;
      if (abort) begin
         state_d = IDLE;
         rem_d   = '0;
         flush   = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (arm) begin
                  state_d = ARMED;
                  clear   = 1'b1;
               end
            end
            ARMED: begin
               if (loggable) begin
                  wr_en = 1'b1;
                  if (hit) begin
                     wr_trig = 1'b1;
                     rem_d   = post_eff;
                     state_d = (post_eff == '0) ? DONE : POST;
                  end
               end
            end
            POST: begin
               if (loggable) begin
                  wr_en = 1'b1;
                  rem_d = rem_q - 1'b1;
                  if (rem_q == CW'(1)) state_d = DONE;
               end
            end
            DONE: begin
               if (level == '0) begin
                  state_d = IDLE;
               end else if (rd_ready) begin
                  rd_adv = 1'b1;
                  if (level == CW'(1)) state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      wr_entry      = '0;
      wr_entry.pc   = XLEN_D'(commit_pc);
      wr_entry.rd   = commit_rd;
      wr_entry.data = XLEN_D'(commit_data);
      wr_entry.ts   = TSW_D'(ts_q);
      wr_entry.trig = wr_trig;
   end

   trace_ring #(.DEPTH(DEPTH)) u_ring (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .flush    (flush),
      .wr_en    (wr_en),
      .wr_entry (wr_entry),
      .rd_adv   (rd_adv),
      .rd_entry (head),
      .level    (level),
      .overflow (overflow)
   );

   // Readout fields are forced to zero whenever nothing is being offered.
   assign rd_pc   = rd_valid ? XLEN'(head.pc)   : '0;
   assign rd_rd   = rd_valid ? head.rd          : '0;
   assign rd_data = rd_valid ? XLEN'(head.data) : '0;
   assign rd_ts   = rd_valid ? TSW'(head.ts)    : '0;
   assign rd_trig = rd_valid && head.trig;
   assign state_o = state_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf: trigger capture, wrap, clamp,
// backpressure, filtering, abort and asynchronous reset.
module tb_commit_trace_buf;

   localparam int XLEN  = 32;
   localparam int DEPTH = 16;
   localparam int TSW   = 16;
   localparam int CW    = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            commit_valid = 1'b0;
   logic [XLEN-1:0] commit_pc = '0;
   logic [4:0]      commit_rd = '0;
   logic [XLEN-1:0] commit_data = '0;
   logic            arm = 1'b0;
   logic            abort = 1'b0;
   logic            trig_rd_en = 1'b0;
   logic [4:0]      trig_rd = '0;
   logic            trig_pc_en = 1'b0;
   logic [XLEN-1:0] trig_pc = '0;
   logic [CW-1:0]   post_count = '0;
   logic            rd_valid;
   logic            rd_ready = 1'b0;
   logic [XLEN-1:0] rd_pc;
   logic [4:0]      rd_rd;
   logic [XLEN-1:0] rd_data;
   logic [TSW-1:0]  rd_ts;
   logic            rd_trig;
   logic [1:0]      state_o;
   logic [CW-1:0]   level;
   logic            overflow;

   int             n_checks = 0;
   int             n_errors = 0;
   int             cyc;
   logic [TSW-1:0] last_ts;
   logic [TSW-1:0] ts1 [1:7];

   commit_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .TSW(TSW), .FILTER_X0(1'b1)) dut (
      .clk(clk), .reset(reset),
      .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_rd(commit_rd),
      .commit_data(commit_data), .arm(arm), .abort(abort),
      .trig_rd_en(trig_rd_en), .trig_rd(trig_rd), .trig_pc_en(trig_pc_en),
      .trig_pc(trig_pc), .post_count(post_count),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_rd(rd_rd),
      .rd_data(rd_data), .rd_ts(rd_ts), .rd_trig(rd_trig),
      .state_o(state_o), .level(level), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Independent cycle count; mirrors the free-running timestamp from reset.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
      commit_valid = 1'b1;
      commit_pc    = pc;
      commit_rd    = rd;
      commit_data  = data;
      last_ts      = cyc[TSW-1:0];
      tick();
      commit_valid = 1'b0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   initial begin
      int xfers;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      check("rst_state", state_o, 0);
      check("rst_level", level, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_ovf", overflow, 0);
      check("rst_pc", rd_pc, 0);

      // Basic rd trigger with two post entries
      trig_rd_en = 1'b1; trig_rd = 5'd4; post_count = 5'd2;
      pulse_arm();
      check("arm_state", state_o, 1);
      for (int i = 1; i <= 7; i++) begin
         do_commit(32'h100 + 32'(4 * i), i[4:0], 32'(i * 17));
         ts1[i] = last_ts;
         if (i == 4) check("basic_post", state_o, 2);
         if (i == 6) begin
            check("basic_done", state_o, 3);
            check("basic_level6", level, 6);
         end
      end
      check("basic_rd7_ignored", level, 6);
      rd_ready = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         check("basic_valid", rd_valid, 1);
         check("basic_rd", rd_rd, i);
         check("basic_trig", rd_trig, (i == 4));
         check("basic_pc", rd_pc, 32'h100 + 32'(4 * i));
         check("basic_data", rd_data, 32'(i * 17));
         check("basic_ts", rd_ts, ts1[i]);
         tick();
      end
      check("basic_idle", state_o, 0);
      check("basic_nvalid", rd_valid, 0);
      rd_ready = 1'b0;

      // Wrap and overflow, PC trigger with no post entries
      trig_rd_en = 1'b0; trig_pc_en = 1'b1; trig_pc = 32'h80; post_count = 5'd0;
      pulse_arm();
      for (int i = 1; i <= 20; i++) do_commit(32'h1000 + 32'(4 * i), i[4:0], 32'(i));
      do_commit(32'h80, 5'd25, 32'hdead);
      check("ovf_done", state_o, 3);
      check("ovf_flag", overflow, 1);
      check("ovf_level", level, 16);
      rd_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         check("ovf_pc", rd_pc, (k == 15) ? 32'h80 : 32'h1000 + 32'(4 * (k + 6)));
         check("ovf_trig", rd_trig, (k == 15));
         tick();
      end
      check("ovf_idle", state_o, 0);
      rd_ready = 1'b0;

      // Post count clamped to DEPTH-1
      trig_pc_en = 1'b0; trig_rd_en = 1'b1; trig_rd = 5'd9; post_count = 5'd16;
      pulse_arm();
      for (int i = 1; i <= 3; i++) do_commit(32'h400 + 32'(i), i[4:0], 32'(i));
      do_commit(32'h409, 5'd9, 32'h9);
      check("clamp_post", state_o, 2);
      for (int i = 10; i < 20; i++) do_commit(32'h400 + 32'(i), i[4:0], 32'(i));
      check("clamp_still_post", state_o, 2);
      for (int i = 20; i < 25; i++) do_commit(32'h400 + 32'(i), i[4:0], 32'(i));
      check("clamp_done", state_o, 3);
      check("clamp_level", level, 16);
      check("clamp_first_rd", rd_rd, 9);
      check("clamp_first_trig", rd_trig, 1);
      pulse_abort();
      check("abort_done_state", state_o, 0);
      check("abort_done_level", level, 0);
      check("abort_done_valid", rd_valid, 0);

      // Backpressure on a three-entry capture
      trig_rd = 5'd2; post_count = 5'd1;
      pulse_arm();
      for (int i = 1; i <= 3; i++) do_commit(32'h200 + 32'(4 * i), i[4:0], 32'(i));
      check("bp_done", state_o, 3);
      check("bp_level", level, 3);
      rd_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("bp_stall_valid", rd_valid, 1);
         check("bp_stall_rd", rd_rd, 1);
         check("bp_stall_pc", rd_pc, 32'h204);
         tick();
      end
      xfers = 0;
      for (int k = 0; k < 20 && xfers < 3; k++) begin
         rd_ready = (k[0] == 1'b0);
         #0;
         if (rd_valid && rd_ready) begin
            check("bp_order", rd_rd, xfers + 1);
            xfers++;
         end
         tick();
      end
      rd_ready = 1'b0;
      check("bp_xfers", xfers, 3);
      check("bp_idle", state_o, 0);
      check("bp_nvalid", rd_valid, 0);

      // x0 filtering and commits outside the capture window
      trig_rd = 5'd0; post_count = 5'd0;
      do_commit(32'h500, 5'd5, 32'h5);
      check("idle_ignore_state", state_o, 0);
      check("idle_ignore_level", level, 0);
      pulse_arm();
      for (int i = 0; i < 3; i++) do_commit(32'h600 + 32'(i), 5'd0, 32'h0);
      check("x0_state", state_o, 1);
      check("x0_level", level, 0);
      do_commit(32'h610, 5'd5, 32'h5);
      check("x0_log_level", level, 1);
      check("x0_log_state", state_o, 1);
      trig_rd = 5'd5;
      do_commit(32'h614, 5'd5, 32'h6);
      check("x0_trig_done", state_o, 3);
      check("x0_trig_level", level, 2);
      do_commit(32'h618, 5'd6, 32'h7);
      check("done_ignore_level", level, 2);
      pulse_arm();
      check("done_arm_state", state_o, 3);
      check("done_arm_level", level, 2);

      // Abort from DONE and mid-POST, commit alongside arm
      pulse_abort();
      check("abort_state", state_o, 0);
      check("abort_level", level, 0);
      check("abort_valid", rd_valid, 0);
      trig_rd = 5'd7; post_count = 5'd4;
      arm = 1'b1; commit_valid = 1'b1; commit_rd = 5'd3; commit_pc = 32'h700;
      tick();
      arm = 1'b0; commit_valid = 1'b0;
      check("arm_commit_state", state_o, 1);
      check("arm_commit_level", level, 0);
      do_commit(32'h704, 5'd3, 32'h3);
      do_commit(32'h708, 5'd7, 32'h7);
      check("midpost_state", state_o, 2);
      do_commit(32'h70c, 5'd8, 32'h8);
      check("midpost_level", level, 3);
      pulse_abort();
      check("abort_post_state", state_o, 0);
      check("abort_post_level", level, 0);

      // Asynchronous reset during readout
      post_count = 5'd0;
      pulse_arm();
      do_commit(32'h300, 5'd7, 32'h77);
      check("rr_valid", rd_valid, 1);
      check("rr_pc", rd_pc, 32'h300);
      #3 reset = 1'b1;
      #1;
      check("async_state", state_o, 0);
      check("async_level", level, 0);
      check("async_valid", rd_valid, 0);
      check("async_pc", rd_pc, 0);
      check("async_data", rd_data, 0);
      check("async_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      check("post_rst_state", state_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
